// File: rtl/pwr_sync_gen.sv
// Sync clock generator for the DC-DC converters: programmable period, two phase-offset
// outputs, double-buffered config applied at period boundaries, runt-free start/stop.
module pwr_sync_gen #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned DEFAULT_DIV   = 100,
  parameter int unsigned DEFAULT_PHASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic [DIV_W-1:0] phase_in,
  input  logic             cfg_load,
  output logic             sync_a,
  output logic             sync_d,
  output logic             active,
  output logic             period_tick,
  output logic             cfg_pending
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_div_s;
  logic [DIV_W-1:0] r_phase_s;
  logic             r_pending;
  logic             r_sync_a;
  logic             r_sync_d;
  logic             r_active;
  logic             r_tick;

  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_phase_nxt;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W:0]   w_pd_sum;
  logic [DIV_W:0]   w_pd;
  logic [DIV_W-1:0] w_div_cap;
  logic [DIV_W-1:0] w_phase_cap;
  logic             w_wrap;
  logic             w_apply;
  logic             w_run_nxt;

  always_comb begin
    w_wrap      = (r_state != ST_IDLE) && (r_cnt == r_div - 1'b1);
    // Config applies at any period boundary (RUN or DRAIN) or at once while idle.
    w_apply     = r_pending && ((r_state == ST_IDLE) || w_wrap);
    w_div_nxt   = w_apply ? r_div_s   : r_div;
    w_phase_nxt = w_apply ? r_phase_s : r_phase;

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en)          w_state_nxt = ST_RUN;
        else if (w_wrap) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (r_state == ST_IDLE || w_wrap) w_cnt_nxt = '0;
    else                              w_cnt_nxt = r_cnt + 1'b1;

    w_run_nxt = (w_state_nxt != ST_IDLE);
    w_half    = w_div_nxt >> 1;
    w_pd_sum  = {1'b0, w_cnt_nxt} + {1'b0, w_phase_nxt};
    w_pd      = (w_pd_sum >= {1'b0, w_div_nxt}) ? w_pd_sum - {1'b0, w_div_nxt} : w_pd_sum;

    w_div_cap   = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    w_phase_cap = (phase_in < w_div_cap) ? phase_in : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_phase   <= DIV_W'(DEFAULT_PHASE);
      r_div_s   <= DIV_W'(DEFAULT_DIV);
      r_phase_s <= DIV_W'(DEFAULT_PHASE);
      r_pending <= 1'b0;
      r_sync_a  <= 1'b0;
      r_sync_d  <= 1'b0;
      r_active  <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_phase   <= w_phase_nxt;
      // A load coinciding with an apply keeps pending set for the new shadow.
      r_pending <= cfg_load | (r_pending & ~w_apply);
      if (cfg_load) begin
        r_div_s   <= w_div_cap;
        r_phase_s <= w_phase_cap;
      end
      r_active  <= w_run_nxt;
      r_sync_a  <= w_run_nxt && (w_cnt_nxt < w_half);
      r_sync_d  <= w_run_nxt && (w_pd < {1'b0, w_half});
      r_tick    <= w_run_nxt && (w_cnt_nxt == w_div_nxt - 1'b1);
    end
  end

  assign sync_a      = r_sync_a;
  assign sync_d      = r_sync_d;
  assign active      = r_active;
  assign period_tick = r_tick;
  assign cfg_pending = r_pending;

endmodule

// File: tb/tb_pwr_sync_gen.sv
// Bench for pwr_sync_gen: directed scenarios then random traffic, all outputs compared
// each cycle against a modulo-arithmetic reference model.
module tb_pwr_sync_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_in = '0;
  logic [15:0] phase_in = '0;
  logic        cfg_load = 1'b0;
  logic        sync_a, sync_d, active, period_tick, cfg_pending;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_run, m_drain, m_pend;
  int m_cnt, m_div, m_phase, m_div_s, m_phase_s;

  pwr_sync_gen #(.DIV_W(16), .DEFAULT_DIV(100), .DEFAULT_PHASE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .phase_in(phase_in),
    .cfg_load(cfg_load), .sync_a(sync_a), .sync_d(sync_d), .active(active),
    .period_tick(period_tick), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit e, input bit ld, input int di, input int pi, input bit r);
    bit at_end, apply;
    if (r) begin
      m_run = 0; m_drain = 0; m_pend = 0; m_cnt = 0;
      m_div = 100; m_phase = 0; m_div_s = 100; m_phase_s = 0;
    end else begin
      at_end = m_run && (m_cnt == m_div - 1);
      apply  = m_pend && (!m_run || at_end);
      if (!m_run) begin
        if (e) begin m_run = 1; m_drain = 0; end
        m_cnt = 0;
      end else begin
        if (m_drain) begin
          if (e) m_drain = 0;
          else if (at_end) m_run = 0;
        end else if (!e) m_drain = 1;
        m_cnt = at_end ? 0 : m_cnt + 1;
      end
      if (apply) begin m_div = m_div_s; m_phase = m_phase_s; m_pend = 0; end
      if (ld) begin
        m_div_s   = (di < 4) ? 4 : di;
        m_phase_s = (pi < m_div_s) ? pi : 0;
        m_pend    = 1;
      end
    end
  endtask

  task automatic compare_all();
    int half;
    half = m_div / 2;
    check("sync_a", sync_a, m_run && (m_cnt < half));
    check("sync_d", sync_d, m_run && (((m_cnt + m_phase) % m_div) < half));
    check("active", active, m_run);
    check("period_tick", period_tick, m_run && (m_cnt == m_div - 1));
    check("cfg_pending", cfg_pending, m_pend);
  endtask

  // One clock: drive at negedge, model follows the edge, compare at next negedge.
  task automatic cyc(input bit e, input bit ld, input int di, input int pi, input bit r);
    en = e; cfg_load = ld; div_in = di[15:0]; phase_in = pi[15:0]; rst = r;
    @(posedge clk);
    model_step(e, ld, di, pi, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until(input int cnt_t, input int div_t, input bit e);
    int guard;
    guard = 0;
    while (!(m_cnt == cnt_t && m_div == div_t) && guard < 400) begin
      cyc(e, 0, 0, 0, 0);
      guard++;
    end
    if (guard >= 400) check("run_until_timeout", guard, 0);
  endtask

  initial begin
    int hi;
    bit re;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Run on defaults, then reset with a pending config: shadow must be discarded.
    repeat (5) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 8, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (205) cyc(1, 0, 0, 0, 0);
    repeat (110) cyc(0, 0, 0, 0, 0);
    // div=8 phase=0 loaded in idle
    cyc(0, 1, 8, 0, 0);
    repeat (24) cyc(1, 0, 0, 0, 0);
    // phase=4: D1 is the complement of A1
    cyc(1, 1, 8, 4, 0);
    repeat (24) cyc(1, 0, 0, 0, 0);
    // div=10 loaded mid-period at cnt=2
    run_until(2, 8, 1);
    cyc(1, 1, 10, 0, 0);
    repeat (25) cyc(1, 0, 0, 0, 0);
    // back to div=8, drop en at cnt=1, re-assert at cnt=5
    cyc(1, 1, 8, 0, 0);
    run_until(1, 8, 1);
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (12) cyc(1, 0, 0, 0, 0);
    run_until(1, 8, 1);
    repeat (12) cyc(0, 0, 0, 0, 0);
    check("stopped_after_drain", active, 0);
    // clamp: div 2 -> 4, phase 9 -> 0
    cyc(0, 1, 2, 9, 0);
    repeat (12) cyc(1, 0, 0, 0, 0);
    // odd divider: 3 high of 7
    cyc(1, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0);
    run_until(0, 7, 1);
    hi = sync_a;
    repeat (6) begin cyc(1, 0, 0, 0, 0); hi += sync_a; end
    check("a1_high_div7", hi, 3);
    // random traffic
    re = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 5) re = ~re;
      cyc(re, $urandom_range(0, 99) < 3, $urandom_range(0, 20), $urandom_range(0, 24),
          $urandom_range(0, 999) < 3);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
